// File: rtl/bcd_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_alu
//  Purpose  : Digit-serial BCD add/subtract controller. One BCD digit per
//             clock, least-significant first, through a single-digit BCD
//             adder with nine's-complement operand select and a start/done
//             handshake.
//  Options  : BCD_SERIAL_RECOMPLEMENT_EN - when defined, a negative
//             difference is recomplemented to its magnitude and neg is set;
//             when undefined the ten's-complement difference is returned
//             and neg is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_alu #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int                 c_W     = 4 * DIGITS;
    localparam int                 c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
`ifdef BCD_SERIAL_RECOMPLEMENT_EN
        S_RECOMP = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state_q,  w_state_d;
    logic [c_W-1:0]       r_a_q,      w_a_d;
    logic [c_W-1:0]       r_b_q,      w_b_d;
    logic                 r_sub_q,    w_sub_d;
    logic [c_IDX_W-1:0]   r_idx_q,    w_idx_d;
    logic                 r_carry_q,  w_carry_d;
    logic [c_W-1:0]       r_result_q, w_result_d;
    logic                 r_cout_q,   w_cout_d;
    logic                 r_neg_q,    w_neg_d;
    logic                 r_err_q,    w_err_d;

    logic                 w_in_recomp;
    logic [3:0]           w_opa;
    logic [3:0]           w_opb;
    logic [4:0]           w_sum;
    logic                 w_corr;
    logic [3:0]           w_digit;

    // True when any 4-bit group of the operand is not a legal BCD digit.
    function automatic logic has_bad_digit(input logic [c_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

`ifdef BCD_SERIAL_RECOMPLEMENT_EN
    assign w_in_recomp = (r_state_q == S_RECOMP);
`else
    assign w_in_recomp = 1'b0;
`endif

    // Shared single-digit BCD adder: operand select, binary add, +6 correction.
    always_comb begin
        w_opa = 4'd0;
        w_opb = 4'd0;
        if (w_in_recomp) begin
            // 0 + nine's complement of the stored digit (plus carry) = ten's complement
            w_opb = 4'd9 - r_result_q[{r_idx_q, 2'b00} +: 4];
        end else begin
            w_opa = r_a_q[{r_idx_q, 2'b00} +: 4];
            w_opb = r_sub_q ? (4'd9 - r_b_q[{r_idx_q, 2'b00} +: 4])
                            : r_b_q[{r_idx_q, 2'b00} +: 4];
        end
        w_sum   = {1'b0, w_opa} + {1'b0, w_opb} + {4'd0, r_carry_q};
        w_corr  = w_sum[4] | (w_sum[3:0] > 4'd9);
        w_digit = w_sum[3:0] + (w_corr ? 4'd6 : 4'd0);
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_sub_d    = r_sub_q;
        w_idx_d    = r_idx_q;
        w_carry_d  = r_carry_q;
        w_result_d = r_result_q;
        w_cout_d   = r_cout_q;
        w_neg_d    = r_neg_q;
        w_err_d    = r_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_a_d      = a;
                    w_b_d      = b;
                    w_sub_d    = sub;
                    w_result_d = '0;
                    w_cout_d   = 1'b0;
                    w_neg_d    = 1'b0;
                    w_err_d    = has_bad_digit(a) | has_bad_digit(b);
                    w_idx_d    = '0;
                    // Subtraction is a + nine's complement(b) + 1
                    w_carry_d  = sub;
                    w_state_d  = S_RUN;
                end
            end

            S_RUN: begin
                w_result_d[{r_idx_q, 2'b00} +: 4] = w_digit;
                w_carry_d = w_corr;
                w_idx_d   = r_idx_q + c_ONE;
                if (r_idx_q == c_LAST) begin
                    w_cout_d  = w_corr;
                    w_idx_d   = '0;
                    w_state_d = S_DONE;
`ifdef BCD_SERIAL_RECOMPLEMENT_EN
                    // No end carry on a subtract means a < b: convert to magnitude
                    if (r_sub_q && !w_corr) begin
                        w_carry_d = 1'b1;
                        w_state_d = S_RECOMP;
                    end
`endif
                end
            end

`ifdef BCD_SERIAL_RECOMPLEMENT_EN
            S_RECOMP: begin
                w_result_d[{r_idx_q, 2'b00} +: 4] = w_digit;
                w_carry_d = w_corr;
                w_idx_d   = r_idx_q + c_ONE;
                if (r_idx_q == c_LAST) begin
                    w_neg_d   = 1'b1;
                    w_idx_d   = '0;
                    w_carry_d = 1'b0;
                    w_state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_sub_q    <= 1'b0;
            r_idx_q    <= '0;
            r_carry_q  <= 1'b0;
            r_result_q <= '0;
            r_cout_q   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_sub_q    <= w_sub_d;
            r_idx_q    <= w_idx_d;
            r_carry_q  <= w_carry_d;
            r_result_q <= w_result_d;
            r_cout_q   <= w_cout_d;
            r_neg_q    <= w_neg_d;
            r_err_q    <= w_err_d;
        end
    end

    assign busy   = (r_state_q == S_RUN) | w_in_recomp;
    assign done   = (r_state_q == S_DONE);
    assign result = r_result_q;
    assign cout   = r_cout_q;
    assign neg    = r_neg_q;
    assign err    = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_alu
//  Purpose  : Self-checking bench for bcd_serial_alu (DIGITS = 4).
//             Honours BCD_SERIAL_RECOMPLEMENT_EN for negative differences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_alu;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          neg;
    logic          err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         cout;
        logic         neg;
        logic         err;
        logic         chk_res;
        int           lat;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];

    bcd_serial_alu #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one operation from IDLE, wait for done, compare against the scoreboard.
    task automatic run_vec(input vec_t v);
        int   c;
        int   cyc;
        int   busy_cnt;
        bit   got;
        vec_t e;
        sb_q.push_back(v);
        a     = v.a;
        b     = v.b;
        sub   = v.sub;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        c        = 1;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && c <= 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                cyc = c;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, e.lat);
            chk("busy_cycles", busy_cnt, e.lat - 1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("neg", {31'd0, neg}, {31'd0, e.neg});
            if (e.chk_res) begin
                chk("result", {16'd0, result}, {16'd0, e.res});
                chk("cout", {31'd0, cout}, {31'd0, e.cout});
            end
            @(posedge clk); #1;
            chk("done_pulse_width", {31'd0, done}, 32'd0);
            if (e.chk_res) begin
                chk("result_held", {16'd0, result}, {16'd0, e.res});
            end
        end
    endtask

    initial begin : main
        int   n_done;
        int   c;
        bit   got;
        logic [W-1:0] cap;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[3] = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, 1'b1, 5};
        vecs[4] = '{16'h4567, 16'h4567, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5};
`ifdef BCD_SERIAL_RECOMPLEMENT_EN
        vecs[5] = '{16'h0012, 16'h0345, 1'b1, 16'h0333, 1'b0, 1'b1, 1'b0, 1'b1, 9};
        vecs[6] = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 9};
`else
        vecs[5] = '{16'h0012, 16'h0345, 1'b1, 16'h9667, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        vecs[6] = '{16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 5};
`endif
        vecs[7] = '{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 5};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags",  {29'd0, cout, neg, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // start held high: one done, next op only after DONE
        a      = 16'h0001;
        b      = 16'h0002;
        sub    = 1'b0;
        start  = 1'b1;
        n_done = 0;
        cap    = '0;
        @(posedge clk); #1;
        for (int k = 1; k <= 6; k++) begin
            if (done) begin
                n_done++;
                cap = result;
            end
            if (k == 6) chk("held_start_idle_gap", {31'd0, busy}, 32'd0);
            else begin
                @(posedge clk); #1;
            end
        end
        chk("held_start_single_done", n_done, 1);
        chk("held_start_result", {16'd0, cap}, 32'h0003);
        @(posedge clk); #1;
        chk("held_start_reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        got   = 1'b0;
        c     = 0;
        while (!got && c < 20) begin
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                c++;
            end
        end
        chk("held_start_second_done", {31'd0, got}, 32'd1);
        chk("held_start_second_result", {16'd0, result}, 32'h0003);
        @(posedge clk); #1;

        // reset during RUN cycle 2 aborts without a done pulse
        a     = 16'h1234;
        b     = 16'h5678;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_flags",  {29'd0, cout, neg, err}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", n_done, 0);

        // normal operation resumes after abort
        run_vec(vecs[3]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Digit-serial BCD add/subtract controller. It sequences a single-digit BCD adder with nine's-complement operand select over a DIGITS-wide packed BCD operand pair, one digit per clock, least-significant digit first. The block sits between a register-file or keypad front end and the result display. It trades the wide combinational BCD chain for a small time-multiplexed datapath with a start/done handshake.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a−b; latched with start.
- a  in  4*DIGITS  packed BCD operand, digit 0 in [3:0]; latched with start.
- b  in  4*DIGITS  packed BCD operand; latched with start.
- busy  out  1  high in RUN and RECOMP.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  4*DIGITS  BCD result; held until the next accepted start.
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (a ≥ b).
- neg  out  1  subtract result negative; tied 0 without the macro.
- err  out  1  some latched operand digit was > 9.

## Operation
- States: IDLE, RUN, RECOMP (macro only), DONE.
- IDLE with start = 1:
  - Latch a, b and sub.
  - Clear result, cout, neg and err.
  - Digit index = 0; carry register = sub; go to RUN.
- IDLE with start = 0: stay in IDLE.
- RUN, one digit per cycle:
  - Operand: b digit when sub = 0, nine's complement of the b digit when sub = 1.
  - Add: binary 4-bit sum with the carry register.
  - Correction: add 6 when the binary carry is set or the sum is > 9.
  - Carry register ← binary carry OR correction condition.
  - Write the corrected digit to result[index]; increment the index.
- RUN exit, after digit DIGITS−1: cout ← final carry. Go to RECOMP if sub = 1, the final carry = 0 and the macro is on; otherwise go to DONE.
- RECOMP:
  - Index = 0, carry = 1.
  - Each digit ← 0 + nine's complement of result[index] + carry, with the same correction rule.
  - Runs DIGITS cycles; neg ← 1; then go to DONE.
- DONE: done = 1 for one cycle, then IDLE. start is ignored here.
- start is ignored whenever the state is not IDLE.
- err: set at latch if any digit of a or b is > 9. The computation still proceeds with the same timing; result digits are unspecified when err = 1.
- rst (any state, including mid-RUN/RECOMP):
  - State → IDLE; index and carry → 0.
  - busy, done, cout, neg, err → 0; result → 0.
  - No done pulse is produced for the aborted operation.

## Timing
- Start sampled at edge 0 → busy = 1 from cycle 1.
- RUN occupies cycles 1..DIGITS.
- DONE in cycle DIGITS+1: done = 1, busy = 0, all outputs final.
- With recomplement: RECOMP occupies cycles DIGITS+1..2·DIGITS; DONE in cycle 2·DIGITS+1.
- result digits update one per cycle during RUN/RECOMP. They are only guaranteed when done = 1 and are held stable after it.
- Earliest next start: the cycle after DONE (back-to-back throughput DIGITS+2 cycles).

## Configuration
- BCD_SERIAL_RECOMPLEMENT_EN defined:
  - A negative subtraction (final carry 0) runs RECOMP.
  - result = magnitude of a − b, neg = 1.
- BCD_SERIAL_RECOMPLEMENT_EN undefined:
  - No RECOMP state.
  - result = ten's complement of the difference (10^DIGITS + a − b), neg constant 0.
  - The sign is read from cout only.

## Test plan
- DIGITS=4: add 1234 + 5678 → result 6912, cout 0, err 0; done exactly 5 cycles after the start edge, busy high 4 cycles.
- Add 9999 + 0001 → result 0000, cout 1; add 0000 + 0000 → 0000, cout 0.
- Sub 5000 − 1234 → result 3766, cout 1, neg 0, done at cycle 5.
- Sub 0012 − 0345:
  - Macro on → result 0333, cout 0, neg 1, done at cycle 9.
  - Macro off → result 9667, cout 0, neg 0, done at cycle 5.
- Robustness, reset and error:
  - start held high through RUN of 0001 + 0002 → a single done with 0003, then a new op accepted only after DONE.
  - rst during RUN cycle 2 → next cycle busy 0, result 0000, no done.
  - a = 00A0 → err 1 at done.
